// File: rtl/rej_parse_pkg.sv
// Shared constants and types for the Kyber rejection-sampling parser.
// Holds the modulus, polynomial length, coefficient width and FSM encoding.
package rej_parse_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;
  localparam int BWID    = 2 * COEF_W;
  localparam int IDX_W   = 8;
  localparam int CNT_W   = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Upper candidate sits in the high half so a plain cast splits the word.
  typedef struct packed {
    logic [COEF_W-1:0] d2;
    logic [COEF_W-1:0] d1;
  } word_t;

endpackage

// File: rtl/rej_parse_if.sv
// Word-in / coefficient-out bus of the rejection parser.
// The master drives start and input words; the slave is the parser itself.
interface rej_parse_if
  import rej_parse_pkg::*;
();

  logic              start;
  logic              in_valid;
  logic [BWID-1:0]   in_data;
  logic              in_ready;
  logic              out_valid;
  logic [COEF_W-1:0] out_coef;
  logic [IDX_W-1:0]  out_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, out_valid, out_coef, out_idx, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, out_valid, out_coef, out_idx, busy, done
  );

endinterface

// File: rtl/rej_parse.sv
// Rejection-sampling parser: splits 24-bit words into two 12-bit candidates,
// keeps those below Q and streams one polynomial of N coefficients with index.
module rej_parse
  import rej_parse_pkg::*;
(
  input logic       clk,
  input logic       rst,
  rej_parse_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              pendValid_q, pendValid_d;
  logic [COEF_W-1:0] pendCoef_q, pendCoef_d;
  logic              outValid_q, outValid_d;
  logic [COEF_W-1:0] outCoef_q, outCoef_d;
  logic [IDX_W-1:0]  outIdx_q, outIdx_d;
  logic              done_q, done_d;

  word_t word;
  logic  d1Ok;
  logic  d2Ok;
  logic  inReady;
  logic  accept;
  logic  lastSlot;

  assign word     = word_t'(bus.in_data);
  assign d1Ok     = word.d1 < COEF_W'(KYBER_Q);
  assign d2Ok     = word.d2 < COEF_W'(KYBER_Q);
  assign inReady  = (state_q == RUN) && !pendValid_q && (issued_q < CNT_W'(KYBER_N));
  // A word offered alongside start belongs to the abandoned polynomial.
  assign accept   = bus.in_valid && inReady && !bus.start;
  assign lastSlot = issued_q == CNT_W'(KYBER_N - 1);

  // issued_q counts coefficients committed to the stream, including a pending d2.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    pendValid_d = pendValid_q;
    pendCoef_d  = pendCoef_q;
    outValid_d  = 1'b0;
    outCoef_d   = outCoef_q;
    outIdx_d    = outIdx_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          issued_d    = '0;
          pendValid_d = 1'b0;
          outIdx_d    = '0;
        end
      end

      RUN: begin
        if (bus.start) begin
          issued_d    = '0;
          pendValid_d = 1'b0;
          outIdx_d    = '0;
        end else if (done_q) begin
          state_d = IDLE;
        end else if (pendValid_q) begin
          outValid_d  = 1'b1;
          outCoef_d   = pendCoef_q;
          outIdx_d    = IDX_W'(issued_q - CNT_W'(1));
          pendValid_d = 1'b0;
          done_d      = issued_q == CNT_W'(KYBER_N);
        end else if (accept) begin
          if (d1Ok) begin
            outValid_d = 1'b1;
            outCoef_d  = word.d1;
            outIdx_d   = IDX_W'(issued_q);
            // When d1 fills the last slot, d2 is dropped even if it passes.
            if (d2Ok && !lastSlot) begin
              pendValid_d = 1'b1;
              pendCoef_d  = word.d2;
              issued_d    = issued_q + CNT_W'(2);
            end else begin
              issued_d = issued_q + CNT_W'(1);
              done_d   = lastSlot;
            end
          end else if (d2Ok) begin
            outValid_d = 1'b1;
            outCoef_d  = word.d2;
            outIdx_d   = IDX_W'(issued_q);
            issued_d   = issued_q + CNT_W'(1);
            done_d     = lastSlot;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      pendValid_q <= 1'b0;
      pendCoef_q  <= '0;
      outValid_q  <= 1'b0;
      outCoef_q   <= '0;
      outIdx_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      pendValid_q <= pendValid_d;
      pendCoef_q  <= pendCoef_d;
      outValid_q  <= outValid_d;
      outCoef_q   <= outCoef_d;
      outIdx_q    <= outIdx_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_coef  = outCoef_q;
  assign bus.out_idx   = outIdx_q;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rej_parse.sv
// Self-checking bench for rej_parse: table vectors, hand-written corner sequences
// and random words compared against a queue-based reference model.
module tb_rej_parse;
  import rej_parse_pkg::*;

  logic clk = 1'b0;
  logic rst;

  rej_parse_if bus();

  rej_parse dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coef;
    int idx;
  } exp_t;

  typedef struct {
    logic [23:0] word;
    int          nOut;
    int          c0;
    int          c1;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[5];

  int passCnt = 0;
  int checkCnt = 0;

  int modelCount = 0;
  bit running = 1'b0;
  bit modelReady = 1'b0;
  bit modelDone = 1'b0;
  bit monEn = 1'b0;
  int doneCount = 0;
  int lastDoneCoef = -1;
  int lastDoneIdx = -1;

  exp_t cur;
  int   mw;
  int   md1;
  int   md2;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: every accepted word contributes its passing candidates,
  // in order, until N coefficients exist; the stream drains one per cycle.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (rst) begin
        running = 1'b0;
        modelCount = 0;
        modelDone = 1'b0;
        expQ.delete();
      end else if (bus.start) begin
        running = 1'b1;
        modelCount = 0;
        modelDone = 1'b0;
        expQ.delete();
      end else begin
        if (modelDone) begin
          running = 1'b0;
          modelDone = 1'b0;
        end
        if (bus.in_valid && modelReady) begin
          mw  = int'(bus.in_data);
          md1 = mw % 4096;
          md2 = mw / 4096;
          if (md1 < 3329 && modelCount < 256) begin
            expQ.push_back('{coef: md1, idx: modelCount});
            modelCount++;
          end
          if (md2 < 3329 && modelCount < 256) begin
            expQ.push_back('{coef: md2, idx: modelCount});
            modelCount++;
          end
        end
      end
    end else if (monEn) begin
      if (bus.done) begin
        doneCount++;
        lastDoneCoef = int'(bus.out_coef);
        lastDoneIdx  = int'(bus.out_idx);
      end
      if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        checkOutput("mon_valid", int'(bus.out_valid), 1);
        checkOutput("mon_coef", int'(bus.out_coef), cur.coef);
        checkOutput("mon_idx", int'(bus.out_idx), cur.idx);
        checkOutput("mon_done", int'(bus.done), int'(cur.idx == 255));
        if (cur.idx == 255) modelDone = 1'b1;
      end else begin
        checkOutput("mon_idle_valid", int'(bus.out_valid), 0);
        checkOutput("mon_idle_done", int'(bus.done), 0);
      end
      checkOutput("mon_busy", int'(bus.busy), int'(running));
      modelReady = running && (expQ.size() == 0) && (modelCount < 256);
      checkOutput("mon_ready", int'(bus.in_ready), int'(modelReady));
    end
  end

  task automatic applyStimulus(input logic [23:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic startPoly();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("start_busy", int'(bus.busy), 1);
    checkOutput("start_no_out", int'(bus.out_valid), 0);
  endtask

  task automatic checkPolyEnd(input string tag, input int d0, input int lastCoef);
    repeat (4) @(negedge clk);
    #1;
    checkOutput({tag, "_done_count"}, doneCount, d0 + 1);
    checkOutput({tag, "_last_coef"}, lastDoneCoef, lastCoef);
    checkOutput({tag, "_last_idx"}, lastDoneIdx, 255);
    checkOutput({tag, "_ready_after"}, int'(bus.in_ready), 0);
    checkOutput({tag, "_busy_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passCnt, checkCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expIdx;
    int d0;
    int cyc;

    vecs[0] = '{24'h000001, 2, 1, 0};
    vecs[1] = '{24'hFFFD01, 0, 0, 0};
    vecs[2] = '{24'h123D00, 2, 3328, 291};
    vecs[3] = '{24'hD01005, 1, 5, 0};
    vecs[4] = '{24'h000D01, 1, 0, 0};

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    monEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", int'(bus.in_ready), 0);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_coef", int'(bus.out_coef), 0);
    checkOutput("rst_out_idx", int'(bus.out_idx), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    // Table vectors within one polynomial.
    startPoly();
    expIdx = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].word);
      @(negedge clk);
      checkOutput("tbl_valid", int'(bus.out_valid), int'(vecs[i].nOut > 0));
      if (vecs[i].nOut > 0) begin
        checkOutput("tbl_coef0", int'(bus.out_coef), vecs[i].c0);
        checkOutput("tbl_idx0", int'(bus.out_idx), expIdx);
        expIdx++;
      end
      checkOutput("tbl_ready", int'(bus.in_ready), int'(vecs[i].nOut != 2));
      if (vecs[i].nOut == 2) begin
        @(negedge clk);
        checkOutput("tbl_valid1", int'(bus.out_valid), 1);
        checkOutput("tbl_coef1", int'(bus.out_coef), vecs[i].c1);
        checkOutput("tbl_idx1", int'(bus.out_idx), expIdx);
        expIdx++;
      end
    end

    // Full polynomial of alternating pairs.
    startPoly();
    d0 = doneCount;
    for (int i = 0; i < 128; i++) applyStimulus(24'h001002);
    checkPolyEnd("full", d0, 1);

    // d1 lands in the final slot, so the passing d2 must be dropped.
    startPoly();
    d0 = doneCount;
    for (int i = 0; i < 127; i++) applyStimulus(24'h001002);
    applyStimulus(24'h000D01);
    applyStimulus(24'h007008);
    checkPolyEnd("edge", d0, 8);

    // Restart via start while d2 is pending.
    startPoly();
    for (int i = 0; i < 20; i++) applyStimulus(24'h003004);
    applyStimulus(24'h005006);
    @(negedge clk);
    checkOutput("rs_d1_coef", int'(bus.out_coef), 6);
    checkOutput("rs_d1_idx", int'(bus.out_idx), 40);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h000009;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("rs_no_pend", int'(bus.out_valid), 0);
    checkOutput("rs_busy", int'(bus.busy), 1);
    applyStimulus(24'h000009);
    @(negedge clk);
    checkOutput("rs_new_coef", int'(bus.out_coef), 9);
    checkOutput("rs_new_idx", int'(bus.out_idx), 0);

    // Reset while d2 is pending.
    for (int i = 0; i < 19; i++) applyStimulus(24'h003004);
    applyStimulus(24'h005006);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rr_no_pend", int'(bus.out_valid), 0);
    checkOutput("rr_busy", int'(bus.busy), 0);
    checkOutput("rr_idx", int'(bus.out_idx), 0);
    checkOutput("rr_ready", int'(bus.in_ready), 0);
    startPoly();
    applyStimulus(24'h00A00B);
    @(negedge clk);
    checkOutput("rr_new_coef", int'(bus.out_coef), 11);
    checkOutput("rr_new_idx", int'(bus.out_idx), 0);

    // Random words until a polynomial completes.
    startPoly();
    d0 = doneCount;
    cyc = 0;
    while (doneCount == d0 && cyc < 4000) begin
      @(negedge clk);
      #1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 24'($urandom);
      cyc++;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rand_done_count", doneCount, d0 + 1);
    checkOutput("rand_last_idx", lastDoneIdx, 255);
    checkOutput("rand_busy_after", int'(bus.busy), 0);

    monEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
